// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives instruction-memory address, and queues decoded fields toward decode.
// Optional stall-cycle performance counter built only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
    parameter int ADDR_W = 7,
    parameter int STEP   = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [4:0]        mem_rd,
    input  logic [4:0]        mem_rs1,
    input  logic [4:0]        mem_rs2,
    input  logic [11:0]       mem_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [11:0]       out_imm,
    output logic              busy,
    output logic [15:0]       stall_cycles
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [11:0]       imm;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    entry_t            head_q, head_d, push_ent;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [PTR_W:0]    cnt_q, cnt_d, cnt_pop;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q;
    logic              pop, push, flush;

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign flush     = redirect & (state_q != S_IDLE);
    assign push_ent  = '{pc: pc_q, rd: mem_rd, rs1: mem_rs1, rs2: mem_rs2, imm: mem_imm};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (flush) begin
            state_d = S_FETCH;
            pc_d    = redirect_pc & ~ADDR_W'(3);
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (cnt_q != FULL || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + ADDR_W'(STEP);
                    end else begin
                        state_d = S_STALL;
                    end
                end
                // Leave STALL as soon as a slot frees; the push itself waits a cycle.
                S_STALL: begin
                    if (halt_req)                    state_d = S_HALT;
                    else if (pop || cnt_q != FULL)   state_d = S_FETCH;
                end
                S_HALT:  if (start) state_d = S_FETCH;
                default: if (start) state_d = S_FETCH;
            endcase
        end
    end

    // head_q mirrors the next head so out_* hold steady when the queue empties.
    always_comb begin
        cnt_pop  = cnt_q - {{PTR_W{1'b0}}, pop};
        rd_nxt   = rd_ptr_q + PTR_W'(pop);
        head_d   = head_q;
        cnt_d    = cnt_pop + {{PTR_W{1'b0}}, push};
        rd_ptr_d = rd_nxt;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        if (flush) begin
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else if (cnt_pop != '0) begin
            head_d = fifo_q[rd_nxt];
        end else if (push) begin
            head_d = push_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            head_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            head_q   <= head_d;
            busy_q   <= (state_d == S_FETCH) || (state_d == S_STALL);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_ent;
    end

    assign mem_addr = pc_q;
    assign busy     = busy_q;
    assign out_pc   = head_q.pc;
    assign out_rd   = head_q.rd;
    assign out_rs1  = head_q.rs1;
    assign out_rs2  = head_q.rs2;
    assign out_imm  = head_q.imm;

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk) begin
        if (!rst)
            stall_q <= '0;
        else if (state_q == S_STALL && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural instruction memory plus a scoreboard of expected accepted entries.
module tb_fetch_ctrl;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst, start, halt_req, redirect, out_ready;
    logic [AW-1:0] redirect_pc, mem_addr, out_pc;
    logic [4:0]    mem_rd, mem_rs1, mem_rs2, out_rd, out_rs1, out_rs2;
    logic [11:0]   mem_imm, out_imm;
    logic          out_valid, busy;
    logic [15:0]   stall_cycles;

    int n_pass = 0;
    int n_chk  = 0;
    logic [AW-1:0] sb[$];

`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_ctrl #(.ADDR_W(AW), .STEP(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .redirect(redirect), .redirect_pc(redirect_pc), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_rs1(mem_rs1), .mem_rs2(mem_rs2), .mem_imm(mem_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .busy(busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a function of address.
    function automatic logic [26:0] mem_word(input logic [AW-1:0] a);
        return {a[6:2], ~a[6:2], a[6:2] ^ 5'h15, a, a[4:0]};
    endfunction

    assign {mem_rd, mem_rs1, mem_rs2, mem_imm} = mem_word(mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) sb.push_back(AW'((first + 4 * i) % 128));
    endtask

    // Each accepted head is popped from the scoreboard and checked against memory contents.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && redirect === 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_accept", {57'd0, out_pc}, 64'hDEAD);
            end else begin
                logic [AW-1:0] e;
                e = sb.pop_front();
                chk("accept_entry", {30'd0, out_pc, out_rd, out_rs1, out_rs2, out_imm},
                    {30'd0, e, mem_word(e)});
            end
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; halt_req = 1'b0; redirect = 1'b0;
        redirect_pc = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_pc", 64'(mem_addr), 0);
        chk("rst_stall", 64'(stall_cycles), 0);
        chk("rst_data", {out_pc, out_rd, out_rs1, out_rs2, out_imm}, 0);

        // Streaming with decode always ready, through the PC wrap.
        rst = 1'b1; out_ready = 1'b1; start = 1'b1;
        push_seq(0, 35);
        step(); start = 1'b0;
        chk("start_busy", 64'(busy), 1);
        chk("start_valid", 64'(out_valid), 0);
        step();
        chk("first_valid", 64'(out_valid), 1);
        chk("first_pc", 64'(out_pc), 0);
        for (int i = 0; i < 34; i++) step();
        halt_req = 1'b1; step(); halt_req = 1'b0;
        chk("wrap_halt_pc", 64'(mem_addr), 12);
        chk("wrap_halt_valid", 64'(out_valid), 0);
        chk("wrap_halt_busy", 64'(busy), 0);
        chk("wrap_sb_empty", 64'(sb.size()), 0);

        // Fill to STALL with decode blocked, then drain; halt at pc=20, resume.
        out_ready = 1'b0;
        rst = 1'b0; step(); rst = 1'b1;
        push_seq(0, 8);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("fill_pc", 64'(mem_addr), 16);
        chk("fill_head", 64'(out_pc), 0);
        for (int i = 0; i < 5; i++) step();
        chk("stall_pc_held", 64'(mem_addr), 16);
        chk("stall_busy", 64'(busy), 1);
        chk("stall_cnt_mid", 64'(stall_cycles), PERF ? 4 : 0);
        out_ready = 1'b1;
        step(); step();
        chk("resume_pc", 64'(mem_addr), 20);
        halt_req = 1'b1; step(); halt_req = 1'b0;
        chk("halt_pc", 64'(mem_addr), 20);
        chk("halt_busy", 64'(busy), 0);
        chk("halt_draining", 64'(out_valid), 1);
        step(); step(); step();
        chk("halt_drained", 64'(out_valid), 0);
        chk("halt_pc_held", 64'(mem_addr), 20);
        chk("halt_out_hold", 64'(out_pc), 16);
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        halt_req = 1'b1; step(); halt_req = 1'b0;
        step();
        chk("halt_sb_empty", 64'(sb.size()), 0);
        chk("stall_cnt_total", 64'(stall_cycles), PERF ? 5 : 0);

        // Redirect with three entries queued.
        out_ready = 1'b0; start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        chk("pre_redir_pc", 64'(mem_addr), 44);
        redirect = 1'b1; redirect_pc = 7'd42; step(); redirect = 1'b0;
        chk("redir_flush", 64'(out_valid), 0);
        chk("redir_pc", 64'(mem_addr), 40);
        chk("redir_busy", 64'(busy), 1);
        out_ready = 1'b1;
        push_seq(40, 3);
        step();
        chk("redir_first_pc", 64'(out_pc), 40);
        step(); step();
        halt_req = 1'b1; step(); halt_req = 1'b0;
        step();
        chk("redir_sb_empty", 64'(sb.size()), 0);
        chk("redir_keeps_stall", 64'(stall_cycles), PERF ? 5 : 0);

        // Reset mid-stream with the queue full and the FSM in STALL.
        out_ready = 1'b0; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("full_valid", 64'(out_valid), 1);
        chk("full_stall_cnt", 64'(stall_cycles), PERF ? 6 : 0);
        rst = 1'b0; step(); rst = 1'b1;
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_pc", 64'(mem_addr), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_stall", 64'(stall_cycles), 0);
        chk("mid_rst_data", {out_pc, out_rd, out_rs1, out_rs2, out_imm}, 0);
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 7'd42; step(); redirect = 1'b0;
        step();
        chk("idle_ignores_redir", 64'(mem_addr), 0);
        chk("idle_not_busy", 64'(busy), 0);
        chk("idle_no_valid", 64'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch sequencer for the PC / instruction-memory datapath.
- Owns the program counter and drives the instruction-memory read address.
- Captures the decoded fields (rd, rs1, rs2, imm) that memory returns combinationally, tags them with their PC and buffers them in a small FIFO toward decode with a valid/ready handshake.
- Handles start, halt, back-pressure stalls and branch redirects.

Parameters:
- ADDR_W, 7: PC / memory address width in bits.
- STEP, 4: PC increment per fetched instruction.
- DEPTH, 4: fetch queue entries. Power of two, minimum 2.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-low reset, sampled at the clk rising edge.
- start, input, 1: begin or resume fetching.
- halt_req, input, 1: stop issuing new fetches.
- redirect, input, 1: branch/jump redirect strobe.
- redirect_pc, input, ADDR_W: redirect target.
- mem_addr, output, ADDR_W: instruction-memory read address; equals pc.
- mem_rd, input, 5: rd field from memory, valid in the same cycle as mem_addr.
- mem_rs1, input, 5: rs1 field from memory.
- mem_rs2, input, 5: rs2 field from memory.
- mem_imm, input, 12: imm field from memory.
- out_valid, output, 1: queue head is valid.
- out_ready, input, 1: decode accepts the head.
- out_pc, output, ADDR_W: PC of the head entry.
- out_rd, output, 5: rd of the head entry.
- out_rs1, output, 5: rs1 of the head entry.
- out_rs2, output, 5: rs2 of the head entry.
- out_imm, output, 12: imm of the head entry.
- busy, output, 1: state is FETCH or STALL.
- stall_cycles, output, 16: performance counter (see Optional Feature).

Behaviour:
- Reset (rst=0 at posedge):
  - pc=0, state=IDLE, queue count=0.
  - out_valid=0; all out_* data outputs=0; busy=0; stall_cycles=0.
  - Reset overrides every other input, including mid-stream: queue contents are discarded.
- States:
  - IDLE: no fetch. start=1 moves to FETCH next cycle. redirect is ignored.
  - FETCH:
    - Push occurs when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
    - A push stores {pc, mem_*} and sets pc <= pc+STEP, truncated to ADDR_W bits (124 -> 0 at default widths).
    - Queue full (count==DEPTH) with no pop: no push, pc held, move to STALL.
  - STALL: pc held. Return to FETCH in the cycle the queue becomes non-full; the first push occurs in the following cycle.
  - HALT:
    - No pushes, pc held. The queue keeps draining to decode.
    - start=1 moves to FETCH and resumes at the held pc.
- halt_req=1 in FETCH or STALL:
  - No push in that cycle; next state is HALT.
  - Already-queued entries remain and keep draining.
- redirect=1 in FETCH, STALL or HALT:
  - Priority over halt_req, start and push.
  - Flush queue: count=0 and out_valid=0 next cycle. A pop attempted in the same cycle is discarded.
  - pc <= redirect_pc with bits [1:0] forced to 0; next state is FETCH.
  - The first entry at the target is pushed the cycle after the redirect.
- Queue:
  - Circular FIFO, first-in first-out.
  - Pop happens when out_valid & out_ready.
  - Push and pop may occur in the same cycle, including when full.
  - out_* always reflect the head entry; they hold their value while out_valid=0 or out_ready=0.
- Latency:
  - A pushed entry appears on out_* the cycle after the push.
  - Throughput is one instruction per cycle while decode keeps out_ready=1.
- busy is a registered function of state.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments by 1 each cycle the state is STALL and saturates at 16'hFFFF.
  - Cleared only by reset; a redirect does not clear it.
- Undefined:
  - stall_cycles is tied to 0 and no counter logic is built.
  - Every other behaviour is identical.

Test Plan:
- Reset then start=1, out_ready=1 held: out_pc sequence 0,4,8,...; first out_valid=1 two cycles after start; out_rd etc. match memory contents at each PC.
- out_ready=0 from start: queue fills with PCs 0,4,8,12; state enters STALL with pc=16 held. Raise out_ready: entries drain in order, fetching resumes at 16; with PERF_EN, stall_cycles equals the number of STALL cycles.
- Run to pc=124 with out_ready=1: next out_pc after 124 is 0 (wrap).
- With the queue holding 3 entries, redirect=1, redirect_pc=7'd42: queue flushed, out_valid=0 next cycle, then out_pc=40, 44,...
- halt_req=1 when pc=20 with 2 entries queued: both entries drain, no push at 20, pc stays 20. Then start=1: out_pc resumes at 20.
- rst=0 asserted mid-stream with the queue full: next cycle out_valid=0, pc=0, state IDLE, busy=0, stall_cycles=0.
